// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle for the UART transmitter.
// The source drives data/valid. The transmitter drives ready, the line and its status.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one byte per valid/ready handshake and shifts it out LSB-first.
// The frame is start, 8 data bits, optional parity, then 1 or 2 stop bits. Every bit lasts BPS_PARA clocks.
module uart_tx_frame #(
    parameter int BPS_PARA   = 1250,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic clk,
    input  logic rst_n,
    uart_tx_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [12:0] BAUD_LAST = 13'(BPS_PARA - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic        ODD_SEL   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    function automatic logic parity_of(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic [2:0]  state_r;
    logic [12:0] baud_cnt_r;
    logic [2:0]  bit_idx_r;
    logic        stop_cnt_r;
    logic [7:0]  shift_r;
    logic        parity_r;
    logic        tx_r;
    logic        ready_r;
    logic        busy_r;
    logic        done_r;
    logic        baud_tick_s;
    logic        accept_s;

    // Bit-boundary strobe and handshake acceptance decode
    always_comb begin
        baud_tick_s = 1'b0;
        accept_s    = 1'b0;
        if ((state_r != ST_IDLE) && (baud_cnt_r == BAUD_LAST)) begin
            baud_tick_s = 1'b1;
        end else begin
            baud_tick_s = 1'b0;
        end
        if ((state_r == ST_IDLE) && bus.tx_valid && ready_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Baud counter: free-runs 0..BPS_PARA-1 while a frame is active, held at 0 in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_r <= 13'd0;
        end else if ((state_r == ST_IDLE) || baud_tick_s) begin
            baud_cnt_r <= 13'd0;
        end else begin
            baud_cnt_r <= baud_cnt_r + 13'd1;
        end
    end

    // Frame sequencer: line level, shift register and status flags all change on bit boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            bit_idx_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shift_r    <= bus.tx_data;
                        parity_r   <= parity_of(bus.tx_data, ODD_SEL);
                        bit_idx_r  <= 3'd0;
                        stop_cnt_r <= 1'b0;
                        tx_r       <= 1'b0;
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick_s) begin
                        tx_r    <= shift_r[0];
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick_s) begin
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
                            if (PARITY_EN != 0) begin
                                tx_r    <= parity_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            // shift_r[0] is on the line, so shift_r[1] is the next bit out
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[1];
                            shift_r   <= {1'b0, shift_r[7:1]};
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick_s) begin
                        tx_r    <= 1'b1;
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_tick_s) begin
                        if (stop_cnt_r == STOP_LAST) begin
                            stop_cnt_r <= 1'b0;
                            done_r     <= 1'b1;
                            ready_r    <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            stop_cnt_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx       = tx_r;
    assign bus.tx_ready = ready_r;
    assign bus.tx_busy  = busy_r;
    assign bus.tx_done  = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: per-cycle scoreboard of {tx, tx_done, tx_ready, tx_busy}
// across four instances (8N1, odd parity, even parity, two stop bits at the default rate).
module tb_uart_tx_frame;

    localparam int B_FAST = 4;
    localparam int B_SLOW = 1250;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] data_d  [4];
    logic       valid_d [4];
    logic       tx_w    [4];
    logic       done_w  [4];
    logic       ready_w [4];
    logic       busy_w  [4];

    uart_tx_if u_if0 ();
    uart_tx_if u_if1 ();
    uart_tx_if u_if2 ();
    uart_tx_if u_if3 ();

    assign u_if0.tx_data = data_d[0];  assign u_if0.tx_valid = valid_d[0];
    assign u_if1.tx_data = data_d[1];  assign u_if1.tx_valid = valid_d[1];
    assign u_if2.tx_data = data_d[2];  assign u_if2.tx_valid = valid_d[2];
    assign u_if3.tx_data = data_d[3];  assign u_if3.tx_valid = valid_d[3];

    assign tx_w[0] = u_if0.tx; assign done_w[0] = u_if0.tx_done; assign ready_w[0] = u_if0.tx_ready; assign busy_w[0] = u_if0.tx_busy;
    assign tx_w[1] = u_if1.tx; assign done_w[1] = u_if1.tx_done; assign ready_w[1] = u_if1.tx_ready; assign busy_w[1] = u_if1.tx_busy;
    assign tx_w[2] = u_if2.tx; assign done_w[2] = u_if2.tx_done; assign ready_w[2] = u_if2.tx_ready; assign busy_w[2] = u_if2.tx_busy;
    assign tx_w[3] = u_if3.tx; assign done_w[3] = u_if3.tx_done; assign ready_w[3] = u_if3.tx_ready; assign busy_w[3] = u_if3.tx_busy;

    uart_tx_frame #(.BPS_PARA(B_FAST), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0));
    uart_tx_frame #(.BPS_PARA(B_FAST), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1));
    uart_tx_frame #(.BPS_PARA(B_FAST), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2));
    uart_tx_frame #(.BPS_PARA(B_SLOW), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(u_if3));

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {tx, tx_done, tx_ready, tx_busy} for each cycle after acceptance
    logic [3:0] exp_q [$];

    function automatic void push_frame(input logic [7:0] b, input int bps, input bit pen,
                                       input bit podd, input int stops);
        logic par;
        par = (^b) ^ podd;
        for (int k = 0; k < bps; k++) exp_q.push_back(4'b0001);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < bps; k++) exp_q.push_back({b[i], 3'b001});
        if (pen)
            for (int k = 0; k < bps; k++) exp_q.push_back({par, 3'b001});
        for (int s = 0; s < stops; s++)
            for (int k = 0; k < bps; k++) exp_q.push_back(4'b1001);
        exp_q.push_back(4'b1110);
    endfunction

    function automatic void push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(4'b1010);
    endfunction

    task automatic test_reset();
        logic [3:0] obs_v;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            obs_v = {tx_w[i], done_w[i], ready_w[i], busy_w[i]};
            n_tests++;
            if (obs_v !== 4'b1010) begin
                n_fail++;
                $display("FAIL reset_in inst%0d: got %b want 1010", i, obs_v);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            obs_v = {tx_w[i], done_w[i], ready_w[i], busy_w[i]};
            n_tests++;
            if (obs_v !== 4'b1010) begin
                n_fail++;
                $display("FAIL reset_out inst%0d: got %b want 1010", i, obs_v);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_v, obs_v;
        int c;
        @(negedge clk);
        data_d[0] = 8'h55; valid_d[0] = 1'b1;
        push_frame(8'h55, B_FAST, 1'b0, 1'b0, 1);
        push_idle(3);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (c == 0) valid_d[0] = 1'b0;
            exp_v = exp_q.pop_front();
            obs_v = {tx_w[0], done_w[0], ready_w[0], busy_w[0]};
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL single_55 cyc %0d: got %b want %b", c, obs_v, exp_v);
            end
            c++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v, obs_v;
        int c;
        @(negedge clk);
        data_d[0] = 8'hA5; valid_d[0] = 1'b1;
        push_frame(8'hA5, B_FAST, 1'b0, 1'b0, 1);
        push_frame(8'h3C, B_FAST, 1'b0, 1'b0, 1);
        push_idle(3);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (c == 0) data_d[0] = 8'h3C;
            if (c == 10 * B_FAST + 1) valid_d[0] = 1'b0;
            exp_v = exp_q.pop_front();
            obs_v = {tx_w[0], done_w[0], ready_w[0], busy_w[0]};
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", c, obs_v, exp_v);
            end
            c++;
        end
    endtask

    task automatic test_parity();
        logic [3:0] exp_v, obs_v;
        int c;
        for (int u = 1; u <= 2; u++) begin
            @(negedge clk);
            data_d[u] = 8'hA5; valid_d[u] = 1'b1;
            push_frame(8'hA5, B_FAST, 1'b1, (u == 1), 1);
            push_idle(2);
            c = 0;
            while (exp_q.size() > 0) begin
                @(negedge clk);
                if (c == 0) valid_d[u] = 1'b0;
                exp_v = exp_q.pop_front();
                obs_v = {tx_w[u], done_w[u], ready_w[u], busy_w[u]};
                n_tests++;
                if (obs_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL parity_%s cyc %0d: got %b want %b", (u == 1) ? "odd" : "even",
                             c, obs_v, exp_v);
                end
                c++;
            end
        end
    endtask

    task automatic test_busy_reject();
        logic [3:0] exp_v, obs_v;
        int c;
        @(negedge clk);
        data_d[0] = 8'h00; valid_d[0] = 1'b1;
        push_frame(8'h00, B_FAST, 1'b0, 1'b0, 1);
        push_idle(4);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (c == 0) valid_d[0] = 1'b0;
            if (c == 20) begin data_d[0] = 8'hFF; valid_d[0] = 1'b1; end
            if (c == 21) valid_d[0] = 1'b0;
            exp_v = exp_q.pop_front();
            obs_v = {tx_w[0], done_w[0], ready_w[0], busy_w[0]};
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL busy_reject cyc %0d: got %b want %b", c, obs_v, exp_v);
            end
            c++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] exp_v, obs_v;
        int c;
        @(negedge clk);
        data_d[0] = 8'hC3; valid_d[0] = 1'b1;
        push_frame(8'hC3, B_FAST, 1'b0, 1'b0, 1);
        // Cycle 17 sits inside data bit 3, which is 0 for 0xC3
        for (c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) valid_d[0] = 1'b0;
            exp_v = exp_q.pop_front();
            obs_v = {tx_w[0], done_w[0], ready_w[0], busy_w[0]};
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d: got %b want %b", c, obs_v, exp_v);
            end
        end
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        obs_v = {tx_w[0], done_w[0], ready_w[0], busy_w[0]};
        n_tests++;
        if (obs_v !== 4'b1010) begin
            n_fail++;
            $display("FAIL async_reset: got %b want 1010", obs_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(3);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            obs_v = {tx_w[0], done_w[0], ready_w[0], busy_w[0]};
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset_idle cyc %0d: got %b want %b", c, obs_v, exp_v);
            end
            c++;
        end
        data_d[0] = 8'h96; valid_d[0] = 1'b1;
        push_frame(8'h96, B_FAST, 1'b0, 1'b0, 1);
        push_idle(2);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (c == 0) valid_d[0] = 1'b0;
            exp_v = exp_q.pop_front();
            obs_v = {tx_w[0], done_w[0], ready_w[0], busy_w[0]};
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset_frame cyc %0d: got %b want %b", c, obs_v, exp_v);
            end
            c++;
        end
    endtask

    task automatic test_two_stop();
        logic [3:0] exp_v, obs_v;
        int c;
        @(negedge clk);
        data_d[3] = 8'h00; valid_d[3] = 1'b1;
        push_frame(8'h00, B_SLOW, 1'b0, 1'b0, 2);
        push_idle(2);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (c == 0) valid_d[3] = 1'b0;
            exp_v = exp_q.pop_front();
            obs_v = {tx_w[3], done_w[3], ready_w[3], busy_w[3]};
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL two_stop cyc %0d: got %b want %b", c, obs_v, exp_v);
            end
            c++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            data_d[i]  = 8'h00;
            valid_d[i] = 1'b0;
        end
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_busy_reject();
        test_reset_mid_frame();
        test_two_stop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART serial transmitter for the STEP board UART bus: accepts one parallel byte per valid/ready handshake, then shifts it out LSB-first on the `tx` line as a start / data / optional parity / stop frame. Bit timing comes from an internal baud counter. The counter uses the same `BPS_PARA` convention as the bus baud generator: one bit time equals `BPS_PARA` system clocks, and the default 1250 at 12 MHz gives 9600 bps. The block is the transmit-side counterpart of the bus receiver and drives the board's UART TX pin directly.

## Interface
- `BPS_PARA`, 1250 — clocks per bit; legal range 2..8192, held in a 13-bit counter.
- `PARITY_EN`, 0 — 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0 — 0 selects even parity, 1 selects odd; ignored when `PARITY_EN` = 0.
- `STOP_BITS`, 1 — number of stop bits, 1 or 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send; sampled only at acceptance.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high when a byte can be accepted (IDLE only).
- `tx`  out  1  serial line; idle high.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- All outputs are registered. Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, baud counter=0, bit index=0.
- Acceptance occurs at a clock edge where state=IDLE and `tx_valid` & `tx_ready` = 1:
  - `tx_data` is latched into the shift register.
  - Parity is latched: XOR of the 8 data bits, inverted when `PARITY_ODD` = 1.
  - State → START; `tx` goes 0; `tx_ready` goes 0; `tx_busy` goes 1.
- Baud counter runs only outside IDLE. It counts 0..`BPS_PARA`−1, wraps to 0, and is cleared in IDLE.
  - The bit boundary is the cycle where the counter equals `BPS_PARA`−1.
  - `tx` changes only at bit boundaries, so every bit lasts exactly `BPS_PARA` clocks.
- Transitions at a bit boundary:
  - START → DATA; `tx` = data[0].
  - DATA after 8 bits → PARITY if `PARITY_EN`, else STOP. Bits are sent LSB first; the bit index is 3 bits and increments 0..7.
  - PARITY → STOP; `tx` = 1.
  - STOP after `STOP_BITS` bit times → IDLE; `tx` stays 1; `tx_done` = 1 for exactly one cycle; `tx_ready` = 1; `tx_busy` = 0.
- `tx_valid` and `tx_data` changes while busy are ignored. There is no queue; the source must hold `tx_valid` until it sees `tx_ready`.
- If `tx_valid` is held high continuously, the next frame starts on the edge after the IDLE cycle, so adjacent frames are separated by exactly one idle-high clock.
- Reset asserted mid-frame: `tx` forces to 1 immediately (asynchronously) and all state returns to the reset values. The partial frame is abandoned with no `tx_done`.

## Timing
- Latency from the acceptance edge to the `tx` falling edge: 0 cycles (same edge).
- Frame length N = 1 + 8 + `PARITY_EN` + `STOP_BITS` bits. `tx` is non-idle for N×`BPS_PARA` clocks after acceptance.
- `tx_done` asserts on the edge N×`BPS_PARA` after acceptance, coincident with `tx_ready` rising.
- Minimum accept-to-accept spacing: N×`BPS_PARA` + 1 clocks.
- With `BPS_PARA` = 2 (minimum), each bit is 2 clocks and the counter toggles 0/1.

## Test plan
- Single byte, `BPS_PARA`=4, 8N1: send 0x55 → `tx` reads 0,1,0,1,0,1,0,1,0,1, each level lasting 4 clocks; `tx_done` pulses 40 clocks after acceptance; `tx_ready` rises on that same cycle.
- Back-to-back, `tx_valid` held high with 0xA5 then 0x3C: both frames are correct, separated by exactly 1 idle-high clock; two `tx_done` pulses 41 clocks apart.
- Parity, `BPS_PARA`=4: 0xA5 with odd parity → parity bit 1; 0xA5 with even parity → parity bit 0; `tx_done` at 44 clocks after acceptance.
- Busy rejection: pulse `tx_valid` with 0xFF at the mid-frame of 0x00 → the frame stays 0x00, `tx_ready` stays 0, and no second frame is sent.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 → `tx`=1 immediately, `tx_ready`=1, `tx_busy`=0, no `tx_done`; the next request after release produces a full, correct frame.
- Two stop bits, default `BPS_PARA`=1250: send 0x00 → `tx` is low for 9×1250 clocks, then high; `tx_done` fires 13750 clocks after acceptance.
